// File: rtl/nn_input_frame_buffer_pkg.sv
// -----------------------------------------------------------------------------
// nn_input_frame_buffer_pkg
// Shared constants and types for the zyNet input ping-pong frame buffer.
// The RTL and its testbench both use this package, so default sizes and the
// read-side state encoding stay in step.
//   DEFAULT_DATA_WIDTH  : sample width (matches dataWidth)
//   DEFAULT_FRAME_LEN   : samples per frame (matches numWeightLayer1)
//   DEFAULT_ADDR_WIDTH  : bank address width, 2**ADDR_WIDTH >= FRAME_LEN
//   rd_state_e          : read-side FSM states
// -----------------------------------------------------------------------------
package nn_input_frame_buffer_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_FRAME_LEN  = 784;
  localparam int DEFAULT_ADDR_WIDTH = 10;
  localparam int FRAME_COUNT_WIDTH  = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,  // waiting for a full bank
    ST_SEND      = 2'd1,  // one RAM read per cycle
    ST_DRAIN     = 2'd2,  // final registered beat on x_valid
    ST_WAIT_DONE = 2'd3   // frame in the layer pipeline, wait for frame_done
  } rd_state_e;

endpackage

// File: rtl/nn_input_frame_buffer_if.sv
// -----------------------------------------------------------------------------
// nn_input_frame_buffer_if
// Groups the AXI-Stream input, the Layer 1 output beat and the status signals
// of the input frame buffer.
//   slave  : the buffer side (takes stream + frame_done, drives the rest)
//   master : the environment side (drives stream + frame_done)
// Signals:
//   s_axis_data/valid/last, s_axis_ready : input stream with backpressure
//   frame_done                           : one-cycle completion pulse
//   x_valid, x_data                      : sample beat to Layer 1
//   busy, err_len, frame_count           : status
// -----------------------------------------------------------------------------
interface nn_input_frame_buffer_if
  import nn_input_frame_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0]        s_axis_data;
  logic                         s_axis_valid;
  logic                         s_axis_last;
  logic                         s_axis_ready;
  logic                         frame_done;
  logic                         x_valid;
  logic [DATA_WIDTH-1:0]        x_data;
  logic                         busy;
  logic                         err_len;
  logic [FRAME_COUNT_WIDTH-1:0] frame_count;

  modport slave (
    input  s_axis_data, s_axis_valid, s_axis_last, frame_done,
    output s_axis_ready, x_valid, x_data, busy, err_len, frame_count
  );

  modport master (
    output s_axis_data, s_axis_valid, s_axis_last, frame_done,
    input  s_axis_ready, x_valid, x_data, busy, err_len, frame_count
  );

endinterface

// File: rtl/nn_frame_bank_ram.sv
// -----------------------------------------------------------------------------
// nn_frame_bank_ram
// Simple dual-port RAM holding both ping-pong banks (2*FRAME_LEN words).
// A location is named by {bank, ptr}; bank 1 starts at word FRAME_LEN.
// Read data is registered: o_rd_data is valid the cycle after i_rd_en.
// Ports:
//   s_axi_aclk, reset       : clock, synchronous active-high reset
//   i_wr_en/bank/ptr/data   : write port
//   i_rd_en/bank/ptr        : read request
//   o_rd_data               : registered read data (0 after reset)
// -----------------------------------------------------------------------------
module nn_frame_bank_ram
  import nn_input_frame_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FRAME_LEN  = DEFAULT_FRAME_LEN,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  s_axi_aclk,
  input  logic                  reset,
  input  logic                  i_wr_en,
  input  logic                  i_wr_bank,
  input  logic [ADDR_WIDTH-1:0] i_wr_ptr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic                  i_rd_bank,
  input  logic [ADDR_WIDTH-1:0] i_rd_ptr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  localparam int DEPTH  = 2 * FRAME_LEN;
  localparam int MEM_AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [MEM_AW-1:0]     w_wr_addr;
  logic [MEM_AW-1:0]     w_rd_addr;

  function automatic logic [MEM_AW-1:0] lin_addr(input logic                  bank,
                                                 input logic [ADDR_WIDTH-1:0] ptr);
    return (bank ? MEM_AW'(FRAME_LEN) : '0) + MEM_AW'(ptr);
  endfunction

  assign w_wr_addr = lin_addr(i_wr_bank, i_wr_ptr);
  assign w_rd_addr = lin_addr(i_rd_bank, i_rd_ptr);

  // NOTE: the storage array has no reset so it maps onto block RAM; its
  // contents are meaningless until written. Sequential state uses <= so every
  // flop samples pre-edge values, independent of statement order.
  always_ff @(posedge s_axi_aclk) begin
    if (i_wr_en) begin
      r_mem[w_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (reset) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[w_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/nn_input_frame_buffer.sv
// -----------------------------------------------------------------------------
// nn_input_frame_buffer
// Ping-pong frame buffer between the AXI-Stream input and Layer 1 of zyNet.
// One bank fills from the stream while the other replays a complete frame to
// Layer 1 as FRAME_LEN back-to-back x_valid beats. A bank is only released
// when the network pulses frame_done, so frames never overlap in the layers.
// Ports:
//   s_axi_aclk, reset : clock, synchronous active-high reset
//   bus (slave)       : stream in with backpressure, frame_done in,
//                       x_valid/x_data out, busy/err_len/frame_count status
// -----------------------------------------------------------------------------
module nn_input_frame_buffer
  import nn_input_frame_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FRAME_LEN  = DEFAULT_FRAME_LEN,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                    s_axi_aclk,
  input  logic                    reset,
  nn_input_frame_buffer_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(FRAME_LEN - 1);

  logic [1:0]                   r_full;       // one full flag per bank
  logic                         r_wr_bank;
  logic                         r_rd_bank;
  logic [ADDR_WIDTH-1:0]        r_wr_ptr;
  logic [ADDR_WIDTH-1:0]        r_rd_ptr;
  logic                         r_err_len;
  logic                         r_x_valid;
  logic [FRAME_COUNT_WIDTH-1:0] r_frame_count;
  rd_state_e                    r_state;
  rd_state_e                    w_state_next;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_wr_fill;
  logic                  w_rd_en;
  logic                  w_rd_release;
  logic                  w_busy;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // ---------------------------------------------------------------- write side
  assign w_ready   = ~r_full[r_wr_bank];
  assign w_accept  = bus.s_axis_valid & w_ready;
  assign w_wr_fill = w_accept & (r_wr_ptr == LAST_PTR);

  always_ff @(posedge s_axi_aclk) begin
    if (reset) begin
      r_wr_bank <= 1'b0;
      r_wr_ptr  <= '0;
      r_err_len <= 1'b0;
    end else if (w_accept) begin
      if (r_wr_ptr == LAST_PTR) begin
        // Length reached: keep the frame even if last was missing.
        r_wr_bank <= ~r_wr_bank;
        r_wr_ptr  <= '0;
        if (!bus.s_axis_last) begin
          r_err_len <= 1'b1;
        end
      end else if (bus.s_axis_last) begin
        // Short frame: drop it and restart the same bank.
        r_err_len <= 1'b1;
        r_wr_ptr  <= '0;
      end else begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
    end
  end

  // Fill and release may coincide; they always target different banks.
  always_ff @(posedge s_axi_aclk) begin
    if (reset) begin
      r_full <= '0;
    end else begin
      if (w_wr_fill) begin
        r_full[r_wr_bank] <= 1'b1;
      end
      if (w_rd_release) begin
        r_full[r_rd_bank] <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------------ read-side FSM
  always_ff @(posedge s_axi_aclk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every signal assigned in a combinational block gets a default first,
  // otherwise any path that skips it would infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:      if (r_full[r_rd_bank]) w_state_next = ST_SEND;
      ST_SEND:      if (r_rd_ptr == LAST_PTR) w_state_next = ST_DRAIN;
      ST_DRAIN:     w_state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: if (bus.frame_done) w_state_next = ST_IDLE;
      default:      w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rd_en      = 1'b0;
    w_busy       = 1'b0;
    w_rd_release = 1'b0;
    case (r_state)
      ST_SEND: begin
        w_rd_en = 1'b1;
        w_busy  = 1'b1;
      end
      ST_DRAIN: begin
        w_busy = 1'b1;
      end
      ST_WAIT_DONE: begin
        w_busy       = 1'b1;
        w_rd_release = bus.frame_done;
      end
      default: ;
    endcase
  end

  // Read pointer, bank toggle and frame counter. x_valid is the read enable
  // delayed to line up with the registered RAM output.
  always_ff @(posedge s_axi_aclk) begin
    if (reset) begin
      r_rd_bank     <= 1'b0;
      r_rd_ptr      <= '0;
      r_x_valid     <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_x_valid <= w_rd_en;
      if (r_state == ST_IDLE) begin
        r_rd_ptr <= '0;
      end else if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_rd_release) begin
        r_rd_bank     <= ~r_rd_bank;
        r_frame_count <= r_frame_count + 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------ storage
  nn_frame_bank_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAME_LEN  (FRAME_LEN),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .s_axi_aclk (s_axi_aclk),
    .reset      (reset),
    .i_wr_en    (w_accept),
    .i_wr_bank  (r_wr_bank),
    .i_wr_ptr   (r_wr_ptr),
    .i_wr_data  (bus.s_axis_data),
    .i_rd_en    (w_rd_en),
    .i_rd_bank  (r_rd_bank),
    .i_rd_ptr   (r_rd_ptr),
    .o_rd_data  (w_rd_data)
  );

  // ------------------------------------------------------------------ outputs
  assign bus.s_axis_ready = w_ready;
  assign bus.x_valid      = r_x_valid;
  assign bus.x_data       = w_rd_data;
  assign bus.busy         = w_busy;
  assign bus.err_len      = r_err_len;
  assign bus.frame_count  = r_frame_count;

endmodule

// File: tb/tb_nn_input_frame_buffer.sv
// -----------------------------------------------------------------------------
// tb_nn_input_frame_buffer
// Self-checking bench for nn_input_frame_buffer with FRAME_LEN=4.
// A transaction-level model (queues of accepted samples and complete frames,
// plus a replay timeline counted from the start of each burst) predicts every
// output each cycle. Directed scenarios come first, then random traffic.
// -----------------------------------------------------------------------------
module tb_nn_input_frame_buffer;
  import nn_input_frame_buffer_pkg::*;

  localparam int DW = DEFAULT_DATA_WIDTH;
  localparam int FL = 4;
  localparam int AW = 2;

  typedef logic [DW-1:0] sample_t;

  logic s_axi_aclk = 1'b0;
  logic reset;

  always #5 s_axi_aclk = ~s_axi_aclk;

  nn_input_frame_buffer_if #(.DATA_WIDTH(DW)) bus ();

  nn_input_frame_buffer #(
    .DATA_WIDTH (DW),
    .FRAME_LEN  (FL),
    .ADDR_WIDTH (AW)
  ) dut (
    .s_axi_aclk (s_axi_aclk),
    .reset      (reset),
    .bus        (bus)
  );

  int n_vectors     = 0;
  int n_miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ reference model
  // cur_q  : samples of the frame currently being received
  // held_q : complete frames waiting for / in replay, oldest first, flattened
  // m_busy : a held frame is being replayed or awaits frame_done
  // m_t    : cycles since replay began; beats appear at m_t = 1..FL
  sample_t     cur_q[$];
  sample_t     held_q[$];
  bit          m_busy;
  int          m_t;
  bit          m_err;
  logic [31:0] m_count;

  function automatic int held_frames();
    return held_q.size() / FL;
  endfunction

  task automatic model_edge(input bit rst, input bit valid, input sample_t data,
                            input bit last, input bit done);
    bit accept;
    bit release_now;
    bit start;
    if (rst) begin
      cur_q.delete();
      held_q.delete();
      m_busy  = 1'b0;
      m_t     = 0;
      m_err   = 1'b0;
      m_count = '0;
      return;
    end
    accept      = valid && (held_frames() < 2);
    release_now = m_busy && (m_t >= FL + 1) && done;
    start       = !m_busy && (held_frames() > 0);
    if (release_now) begin
      repeat (FL) void'(held_q.pop_front());
      m_busy  = 1'b0;
      m_count = m_count + 1;
    end else if (start) begin
      m_busy = 1'b1;
      m_t    = 0;
    end else if (m_busy && m_t <= FL) begin
      m_t++;
    end
    if (accept) begin
      cur_q.push_back(data);
      if (cur_q.size() == FL) begin
        if (!last) m_err = 1'b1;
        foreach (cur_q[i]) held_q.push_back(cur_q[i]);
        cur_q.delete();
      end else if (last) begin
        m_err = 1'b1;
        cur_q.delete();
      end
    end
  endtask

  task automatic check_outputs();
    bit exp_xv;
    bit exp_rdy;
    exp_xv  = m_busy && (m_t >= 1) && (m_t <= FL);
    exp_rdy = held_frames() < 2;
    check("s_axis_ready", 32'(bus.s_axis_ready), 32'(exp_rdy));
    check("x_valid",      32'(bus.x_valid),      32'(exp_xv));
    if (exp_xv) check("x_data", 32'(bus.x_data), 32'(held_q[m_t-1]));
    check("busy",         32'(bus.busy),         32'(m_busy));
    check("err_len",      32'(bus.err_len),      32'(m_err));
    check("frame_count",  bus.frame_count,       m_count);
  endtask

  // One clock: drive at the falling edge, model at the rising edge, compare at
  // the next falling edge.
  task automatic tick(input bit rst, input bit valid, input sample_t data,
                      input bit last, input bit done);
    reset            = rst;
    bus.s_axis_valid = valid;
    bus.s_axis_data  = data;
    bus.s_axis_last  = last;
    bus.frame_done   = done;
    @(posedge s_axi_aclk);
    model_edge(rst, valid, data, last, done);
    @(negedge s_axi_aclk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, sample_t'($urandom), 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, '0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, '0, 1'b0, 1'b0);
    check("reset_x_data", 32'(bus.x_data), 32'h0);
  endtask

  // Holds the beat until the buffer takes it.
  task automatic send_beat(input sample_t data, input bit last);
    bit acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      acc = held_frames() < 2;
      tick(1'b0, 1'b1, data, last, 1'b0);
    end
    if (!acc) check("beat_accept_timeout", 32'(bus.s_axis_ready), 32'h1);
  endtask

  task automatic send_frame(input sample_t base);
    for (int i = 0; i < FL; i++) send_beat(base + sample_t'(i), i == FL - 1);
  endtask

  // Runs until the oldest frame has been replayed, then pulses frame_done.
  task automatic release_frame();
    int n = 0;
    while (!(m_busy && m_t == FL + 1) && n < 40) begin
      tick(1'b0, 1'b0, '0, 1'b0, 1'b0);
      n++;
    end
    if (n == 40) check("wait_done_timeout", 32'(bus.busy), 32'h0);
    tick(1'b0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    bus.s_axis_valid = 1'b0;
    bus.s_axis_data  = '0;
    bus.s_axis_last  = 1'b0;
    bus.frame_done   = 1'b0;
    reset            = 1'b1;

    do_reset();

    // Single frame 1..4, then completion.
    send_frame(16'd1);
    release_frame();
    idle(2);

    // Back-to-back frames 1..8; beat 9 offered while both banks are full.
    send_frame(16'd1);
    send_frame(16'd5);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 16'd9, 1'b0, 1'b0);
    release_frame();
    release_frame();
    idle(2);

    // Short frame (dropped) followed by a good one.
    send_beat(16'd10, 1'b0);
    send_beat(16'd11, 1'b1);
    send_frame(16'd20);
    release_frame();

    // Missing last on the final beat: error flagged, frame kept.
    do_reset();
    for (int i = 0; i < FL; i++) send_beat(sample_t'(30 + i), 1'b0);
    release_frame();

    // Spurious frame_done while idle and in the middle of a burst.
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, '0, 1'b0, 1'b1);
    send_frame(16'd40);
    for (int i = 0; i < 20 && !(m_busy && m_t == FL + 1); i++)
      tick(1'b0, 1'b0, '0, 1'b0, m_busy && (m_t == 2 || m_t == FL));
    release_frame();

    // Reset after two output beats, then a fresh frame 5..8.
    send_frame(16'd50);
    for (int i = 0; i < 20 && !(m_busy && m_t == 2); i++) idle(1);
    tick(1'b1, 1'b0, '0, 1'b0, 1'b0);
    idle(1);
    send_frame(16'd5);
    release_frame();

    // Random traffic: mostly well-formed frames, occasional framing errors,
    // random frame_done pulses and rare resets.
    for (int i = 0; i < 3000; i++) begin
      bit      v;
      bit      l;
      bit      d;
      bit      r;
      sample_t x;
      v = $urandom_range(0, 3) != 0;
      l = (cur_q.size() == FL - 1) ^ ($urandom_range(0, 9) == 0);
      d = $urandom_range(0, 3) == 0;
      r = $urandom_range(0, 499) == 0;
      x = sample_t'($urandom);
      tick(r, v, x, l, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
